alu_rs_multi: RTL and testbench
===============================

Name: alu_rs_multi

Overview:
- Parametrised successor to the single-broadcast ALU reservation station.
- Holds up to DEPTH pending ALU ops and snoops NBC broadcast channels for operand wakeup.
- Issues oldest-ready-first into a registered result stage with a valid/ready output handshake.
- Sits between dispatch and the CDB/ROB writeback arbiter; supports pipeline flush.

Parameters:
- DEPTH, 8: number of reservation entries (>=2).
- DATA_W, 32: operand/result width.
- TAG_W, 5: ROB tag width.
- NBC, 2: number of broadcast (wakeup) channels.
- TAG_INVALID, all-ones in TAG_W: tag value meaning "operand present".

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- flush  in  1  discard all entries and the output register.
- in_valid  in  1  dispatch offers an entry.
- in_ready  out  1  station can accept this cycle.
- in_target  in  TAG_W  destination ROB tag.
- in_op  in  4  ALU op, codebase ALU_* encoding.
- in_val1, in_val2  in  DATA_W  operand values (meaningful when matching tag == TAG_INVALID).
- in_tag1, in_tag2  in  TAG_W  producer tags or TAG_INVALID.
- bc_valid  in  NBC  per-channel broadcast valid.
- bc_tag  in  NBC*TAG_W  channel k at bits [k*TAG_W +: TAG_W].
- bc_val  in  NBC*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer takes the result.
- out_target  out  TAG_W  ROB tag of the result.
- out_result  out  DATA_W  computed value.
- count  out  clog2(DATA_W... DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst==0 at edge) and flush: all entries invalid, count=0, out_valid=0, out_target=TAG_INVALID, out_result=0. Reset wins over flush; flush wins over all other same-cycle events, including insert and issue.
- in_ready = (count < DEPTH). No same-cycle dequeue bypass. An accept occurs when in_valid && in_ready.
- Entries form a collapsing age queue. Index 0 is oldest. A new entry is written at index count after collapse.
- Wakeup: for each valid entry operand with tag != TAG_INVALID, if any channel k has bc_valid[k] && bc_tag[k]==tag, latch bc_val[k] and set tag to TAG_INVALID at the edge. On a multi-channel match, the lowest k wins.
- The same wakeup check is applied to the incoming entry's operands in its accept cycle, so there is no missed-broadcast window.
- Ready entry: valid with both tags == TAG_INVALID, using registered state only (see Optional Feature).
- Issue condition: (!out_valid || out_ready) && some ready entry exists.
- On issue, the lowest-index ready entry is selected. At the edge its result loads into out_target/out_result, out_valid=1, and the entry is removed; younger entries shift down by one.
- If out_valid && !out_ready: the output holds stable and no issue occurs.
- If out_ready and no ready entry: out_valid goes to 0 next cycle.
- Latency: entry accepted with ready operands at edge N -> out_valid high after edge N+1. Wakeup at edge N -> out_valid after edge N+1.
- Simultaneous insert and issue in one cycle is legal: count is unchanged, and the new entry lands at index count-1.
- Ops (SH = src2[clog2(DATA_W)-1:0]):
  - ADD/ADDU = s1+s2; SUB/SUBU = s1-s2 (wrap mod 2^DATA_W, no overflow trap).
  - AND, OR, NOR, XOR bitwise.
  - SLL = s1<<SH; SRL = s1>>SH; SRA = $signed(s1)>>>SH.
  - ROR = rotate s1 right by SH (SH=0 returns s1).
  - SEQ, SLT (signed), SLTU return 1 or 0.
  - Undefined op code returns 0.

Optional Feature:
- Macro ALU_RS_WAKE_BYPASS_EN.
- Defined: ready evaluation also counts operands matched by a broadcast in the current cycle, forwarding bc_val into the ALU. An entry can issue in the same cycle its last operand is broadcast. An incoming entry whose operands are ready or woken in its accept cycle may issue directly that cycle when no older entry is ready; it then never occupies a slot. This saves one cycle of latency.
- Undefined: ready is evaluated from registered tags only, as in Behaviour.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, out_target=TAG_INVALID, no accept.
- Simple: insert ADD val1=7 val2=5 tags invalid target=3 at edge N -> out_valid=1, out_target=3, out_result=12 after edge N+1.
- Wakeup/order: entry A (target 1, tag1=9) inserted, then B (target 2, SUB 10-4, ready); broadcast ch1 tag9 val=20 while B issues -> first B=6, then A issues next.
- Full and backpressure: hold out_ready=0, insert DEPTH+1 ready entries -> in_ready=0 at count=8. The first result holds stable. Order is preserved once out_ready=1.
- Dual-channel collision: both channels broadcast tag 4 with vals 11 and 22 -> operand latches 11 (ch0).
- Flush mid-operation: 5 entries pending, out_valid=1, flush together with in_valid -> count=0, out_valid=0 next cycle, new entry dropped.

Source files
------------

// File: rtl/alu_rs_multi.sv
// ALU reservation station: collapsing age queue, multi-channel wakeup, oldest-ready issue, registered result.
// Optional macro ALU_RS_WAKE_BYPASS_EN lets same-cycle broadcasts count toward readiness and issue.
module alu_rs_multi #(
    parameter int               DEPTH       = 8,
    parameter int               DATA_W      = 32,
    parameter int               TAG_W       = 5,
    parameter int               NBC         = 2,
    parameter logic [TAG_W-1:0] TAG_INVALID = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAG_W-1:0]        in_target,
    input  logic [3:0]              in_op,
    input  logic [DATA_W-1:0]       in_val1,
    input  logic [DATA_W-1:0]       in_val2,
    input  logic [TAG_W-1:0]        in_tag1,
    input  logic [TAG_W-1:0]        in_tag2,
    input  logic [NBC-1:0]          bc_valid,
    input  logic [NBC*TAG_W-1:0]    bc_tag,
    input  logic [NBC*DATA_W-1:0]   bc_val,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TAG_W-1:0]        out_target,
    output logic [DATA_W-1:0]       out_result,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDU = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_ROR  = 4'd11;
    localparam logic [3:0] ALU_SEQ  = 4'd12;
    localparam logic [3:0] ALU_SLT  = 4'd13;
    localparam logic [3:0] ALU_SLTU = 4'd14;

    typedef struct packed {
        logic [3:0]        op;
        logic [TAG_W-1:0]  target;
        logic [TAG_W-1:0]  tag1;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
    } entry_t;

    entry_t            ent_q [DEPTH];
    entry_t            ent_w [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            in_raw;
    entry_t            in_ent_w;
    entry_t            iss_ent;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [TAG_W-1:0]  out_target_q, out_target_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [DEPTH-1:0]  ready;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              any_ready, out_free, accept, from_slot, direct, issue, store_new;

    // Lowest channel wins: once an operand is woken its tag no longer matches later channels.
    function automatic entry_t wake_f(input entry_t e, input logic [NBC-1:0] v,
                                      input logic [NBC*TAG_W-1:0] t, input logic [NBC*DATA_W-1:0] d);
        entry_t r;
        r = e;
        for (int k = 0; k < NBC; k++) begin
            if (r.tag1 != TAG_INVALID && v[k] && t[k*TAG_W +: TAG_W] == r.tag1) begin
                r.tag1 = TAG_INVALID;
                r.val1 = d[k*DATA_W +: DATA_W];
            end
            if (r.tag2 != TAG_INVALID && v[k] && t[k*TAG_W +: TAG_W] == r.tag2) begin
                r.tag2 = TAG_INVALID;
                r.val2 = d[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [SH_W-1:0]   sh;
        logic [DATA_W-1:0] res;
        sh  = b[SH_W-1:0];
        res = '0;
        case (op)
            ALU_ADD, ALU_ADDU: res = a + b;
            ALU_SUB, ALU_SUBU: res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_SLL:  res = a << sh;
            ALU_SRL:  res = a >> sh;
            ALU_SRA:  res = $unsigned($signed(a) >>> sh);
            ALU_ROR:  res = DATA_W'({a, a} >> sh);
            ALU_SEQ:  res = {{(DATA_W-1){1'b0}}, a == b};
            ALU_SLT:  res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: res = {{(DATA_W-1){1'b0}}, a < b};
            default:  res = '0;
        endcase
        return res;
    endfunction

    // NOTE: every variable in this block gets a default before any conditional write, so no latches.
    always_comb begin
        in_raw.op     = in_op;
        in_raw.target = in_target;
        in_raw.tag1   = in_tag1;
        in_raw.tag2   = in_tag2;
        in_raw.val1   = in_val1;
        in_raw.val2   = in_val2;
        in_ent_w      = wake_f(in_raw, bc_valid, bc_tag, bc_val);

        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i] = wake_f(ent_q[i], bc_valid, bc_tag, bc_val);
`ifdef ALU_RS_WAKE_BYPASS_EN
            ready[i] = (CNT_W'(i) < count_q) && ent_w[i].tag1 == TAG_INVALID
                       && ent_w[i].tag2 == TAG_INVALID;
`else
            ready[i] = (CNT_W'(i) < count_q) && ent_q[i].tag1 == TAG_INVALID
                       && ent_q[i].tag2 == TAG_INVALID;
`endif
        end

        any_ready = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end

        in_ready  = count_q < CNT_W'(DEPTH);
        accept    = in_valid && in_ready;
        out_free  = !out_valid_q || out_ready;
        from_slot = out_free && any_ready;
`ifdef ALU_RS_WAKE_BYPASS_EN
        direct    = out_free && !any_ready && accept
                    && in_ent_w.tag1 == TAG_INVALID && in_ent_w.tag2 == TAG_INVALID;
`else
        direct    = 1'b0;
`endif
        issue     = from_slot || direct;
        store_new = accept && !direct;
        iss_ent   = direct ? in_ent_w : ent_w[sel_idx];

        // Collapse: entries younger than the issued one move down a slot.
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_w[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (from_slot && IDX_W'(i) >= sel_idx) begin
                ent_d[i] = ent_w[i+1];
            end
        end
        wr_idx = IDX_W'(count_q - CNT_W'(from_slot));
        if (store_new) begin
            ent_d[wr_idx] = in_ent_w;
        end
        count_d = count_q + CNT_W'(store_new) - CNT_W'(from_slot);

        out_valid_d  = out_valid_q;
        out_target_d = out_target_q;
        out_result_d = out_result_q;
        if (issue) begin
            out_valid_d  = 1'b1;
            out_target_d = iss_ent.target;
            out_result_d = alu_f(iss_ent.op, iss_ent.val1, iss_ent.val2);
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_target_q <= TAG_INVALID;
            out_result_q <= '0;
        end else begin
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_target_q <= out_target_d;
            out_result_q <= out_result_d;
        end
    end

    // NOTE: entry payload is not reset; occupancy is defined solely by count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

    assign out_valid  = out_valid_q;
    assign out_target = out_target_q;
    assign out_result = out_result_q;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_rs_multi.sv
// Directed bench for alu_rs_multi (default build): scoreboard of expected results, checked at each output handshake.
module tb_alu_rs_multi;

    localparam logic [4:0] INV = 5'h1f;
    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADDU = 4'd1, OP_SUB = 4'd2,  OP_SUBU = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR   = 4'd5, OP_XOR = 4'd6,  OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL  = 4'd9, OP_SRA = 4'd10, OP_ROR  = 4'd11;
    localparam logic [3:0] OP_SEQ = 4'd12, OP_SLT  = 4'd13, OP_SLTU = 4'd14, OP_BAD = 4'd15;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  in_target, in_tag1, in_tag2, out_target;
    logic [3:0]  in_op;
    logic [31:0] in_val1, in_val2, out_result;
    logic [1:0]  bc_valid;
    logic [9:0]  bc_tag;
    logic [63:0] bc_val;
    logic [3:0]  count;

    typedef struct {
        logic [4:0]  target;
        logic [31:0] result;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0]  b1_op [9] = '{OP_ADD, OP_SUBU, OP_NOR, OP_SRA, OP_ROR, OP_ROR, OP_SLT, OP_SLTU, OP_BAD};
    logic [31:0] b1_a  [9] = '{32'hffffffff, 32'd3, 32'hf0f0f0f0, 32'h80000000, 32'h1,
                               32'h12345678, 32'hffffffff, 32'hffffffff, 32'h5};
    logic [31:0] b1_b  [9] = '{32'd1, 32'd5, 32'h0f0f0000, 32'd4, 32'd1, 32'd32, 32'd1, 32'd1, 32'd7};
    logic [3:0]  b2_op [9] = '{OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SEQ, OP_SEQ, OP_ADDU, OP_SUB};
    logic [31:0] b2_a  [9] = '{32'hff00ff00, 32'hff00ff00, 32'hff00ff00, 32'h1, 32'h80000000,
                               32'd5, 32'd5, 32'h7fffffff, 32'd0};
    logic [31:0] b2_b  [9] = '{32'h0ff00ff0, 32'h0ff00ff0, 32'h0ff00ff0, 32'd31, 32'd35,
                               32'd5, 32'd6, 32'd1, 32'd1};

    alu_rs_multi dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_target  (in_target),
        .in_op      (in_op),
        .in_val1    (in_val1),
        .in_val2    (in_val2),
        .in_tag1    (in_tag1),
        .in_tag2    (in_tag2),
        .bc_valid   (bc_valid),
        .bc_tag     (bc_tag),
        .bc_val     (bc_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_target (out_target),
        .out_result (out_result),
        .count      (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            OP_ADD, OP_ADDU: return a + b;
            OP_SUB, OP_SUBU: return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
            OP_ROR:  return (sh == 5'd0) ? a : ((a >> sh) | (a << (6'd32 - {1'b0, sh})));
            OP_SEQ:  return (a == b) ? 32'd1 : 32'd0;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] tgt, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t1, input logic [4:0] t2);
        in_valid  = 1'b1;
        in_target = tgt;
        in_op     = op;
        in_val1   = a;
        in_val2   = b;
        in_tag1   = t1;
        in_tag2   = t2;
    endtask

    task automatic expect_res(input logic [4:0] tgt, input logic [31:0] res);
        exp_t e;
        e.target = tgt;
        e.result = res;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            tick();
            n++;
        end
        check("drain_done", 32'(n < 60), 32'd1);
    endtask

    // Scoreboard: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_target", 32'(out_target), 32'(INV));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_target", 32'(out_target), 32'(e.target));
                check("sb_result", out_result, e.result);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1; bc_valid = '0; bc_tag = '0; bc_val = '0;
        send(5'd7, OP_ADD, 32'd1, 32'd2, INV, INV);
        tick(); tick();
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_target", 32'(out_target), 32'(INV));
        check("reset_out_result", out_result, 32'd0);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        check("idle_count", 32'(count), 32'd0);

        // Simple ADD: accepted at edge N, visible after N+1.
        send(5'd3, OP_ADD, 32'd7, 32'd5, INV, INV);
        expect_res(5'd3, model(OP_ADD, 32'd7, 32'd5));
        tick();
        in_valid = 1'b0;
        check("simple_count_after_accept", 32'(count), 32'd1);
        check("simple_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        check("simple_valid", 32'(out_valid), 32'd1);
        check("simple_target", 32'(out_target), 32'd3);
        check("simple_result", out_result, 32'd12);
        check("simple_count_empty", 32'(count), 32'd0);
        tick();
        check("simple_valid_drops", 32'(out_valid), 32'd0);

        // Wakeup and ordering: B (younger, ready) issues while A is woken on channel 1.
        send(5'd1, OP_ADD, 32'd0, 32'd100, 5'd9, INV);
        tick();
        send(5'd2, OP_SUB, 32'd10, 32'd4, INV, INV);
        expect_res(5'd2, 32'd6);
        expect_res(5'd1, 32'd120);
        tick();
        in_valid = 1'b0;
        check("wake_count_two", 32'(count), 32'd2);
        check("wake_none_ready_yet", 32'(out_valid), 32'd0);
        bc_valid = 2'b10; bc_tag = {5'd9, 5'd0}; bc_val = {32'd20, 32'd0};
        tick();
        bc_valid = '0;
        check("wake_first_is_b", 32'(out_target), 32'd2);
        check("wake_count_one", 32'(count), 32'd1);
        tick();
        check("wake_second_is_a", 32'(out_target), 32'd1);
        check("wake_a_result", out_result, 32'd120);
        drain();

        // Dual-channel collision on the same tag: channel 0 wins.
        send(5'd5, OP_ADD, 32'd0, 32'd0, 5'd4, INV);
        expect_res(5'd5, 32'd11);
        tick();
        in_valid = 1'b0;
        bc_valid = 2'b11; bc_tag = {5'd4, 5'd4}; bc_val = {32'd22, 32'd11};
        tick();
        bc_valid = '0;
        tick();
        check("collide_target", 32'(out_target), 32'd5);
        check("collide_result", out_result, 32'd11);
        drain();

        // Incoming entry woken in its own accept cycle (channel 1 match, channel 0 unrelated).
        send(5'd6, OP_SLL, 32'd1, 32'd0, INV, 5'd6);
        expect_res(5'd6, 32'd8);
        bc_valid = 2'b11; bc_tag = {5'd6, 5'd7}; bc_val = {32'd3, 32'd99};
        tick();
        in_valid = 1'b0; bc_valid = '0;
        tick();
        check("inwake_valid", 32'(out_valid), 32'd1);
        check("inwake_result", out_result, 32'd8);
        drain();

        // Full and backpressure: first result parks in the output, eight more fill the queue.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(5'(10 + i), b1_op[i], b1_a[i], b1_b[i], INV, INV);
            expect_res(5'(10 + i), model(b1_op[i], b1_a[i], b1_b[i]));
            tick();
        end
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        send(5'd19, OP_ADD, 32'd1, 32'd1, INV, INV);
        tick();
        in_valid = 1'b0;
        check("full_reject_count", 32'(count), 32'd8);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_target", 32'(out_target), 32'd10);
        tick();
        check("hold_target_later", 32'(out_target), 32'd10);
        check("hold_result_later", out_result, 32'd0);
        out_ready = 1'b1;
        drain();

        // Streaming with a ready consumer: back-to-back inserts and issues.
        for (int i = 0; i < 9; i++) begin
            send(5'(i), b2_op[i], b2_a[i], b2_b[i], INV, INV);
            expect_res(5'(i), model(b2_op[i], b2_a[i], b2_b[i]));
            tick();
        end
        in_valid = 1'b0;
        check("stream_count_low", 32'(count), 32'd1);
        drain();

        // Flush with pending entries and a held result; the same-cycle insert is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(5'(20 + i), OP_ADD, 32'(i), 32'd1, INV, INV);
            tick();
        end
        in_valid = 1'b0;
        check("preflush_count", 32'(count), 32'd5);
        check("preflush_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        send(5'd26, OP_ADD, 32'd1, 32'd1, INV, INV);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_target", 32'(out_target), 32'(INV));
        check("flush_result", out_result, 32'd0);
        out_ready = 1'b1;
        tick(); tick(); tick();
        check("flush_dropped_count", 32'(count), 32'd0);
        check("flush_dropped_valid", 32'(out_valid), 32'd0);
        check("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
